p2s_cond: RTL and testbench

Parallel-to-serial transmitter for the 4-lane link; it is the transmit-side counterpart of the lane deserializer.
- Accepts one 4-lane parallel word (DATA_W bits per lane) through a valid/ready handshake.
- Shifts the word out on 4 serial lanes, one bit per lane per enabled clock.
- Provides frame, active and done markers for the link and the bench.

---
 rtl/p2s_cond_if.sv | 31 +++
 rtl/p2s_cond.sv | 133 +++++++++++++
 tb/tb_p2s_cond.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/p2s_cond_if.sv
// Handshake, parallel-word and serial-lane bundle for the 4-lane p2s transmitter.
// The master drives the parallel words and controls; the slave (p2s_cond) drives the serial side.
interface p2s_cond_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] IN_LANE3_p2s;
    logic [DATA_W-1:0] IN_LANE2_p2s;
    logic [DATA_W-1:0] IN_LANE1_p2s;
    logic [DATA_W-1:0] IN_LANE0_p2s;
    logic              IN_VALID_p2s;
    logic              OUT_READY_p2s;
    logic [1:0]        IN_MODO_p2s;
    logic              IN_DIR_p2s;
    logic              IN_ENB_p2s;
    logic [3:0]        OUT_LANE_p2s;
    logic              OUT_FRAME_p2s;
    logic              OUT_ACTIVE_p2s;
    logic              OUT_DONE_p2s;

    modport master (
        output IN_LANE3_p2s, IN_LANE2_p2s, IN_LANE1_p2s, IN_LANE0_p2s,
        output IN_VALID_p2s, IN_MODO_p2s, IN_DIR_p2s, IN_ENB_p2s,
        input  OUT_READY_p2s, OUT_LANE_p2s, OUT_FRAME_p2s, OUT_ACTIVE_p2s, OUT_DONE_p2s
    );

    modport slave (
        input  IN_LANE3_p2s, IN_LANE2_p2s, IN_LANE1_p2s, IN_LANE0_p2s,
        input  IN_VALID_p2s, IN_MODO_p2s, IN_DIR_p2s, IN_ENB_p2s,
        output OUT_READY_p2s, OUT_LANE_p2s, OUT_FRAME_p2s, OUT_ACTIVE_p2s, OUT_DONE_p2s
    );
endinterface

// File: rtl/p2s_cond.sv
// 4-lane parallel-to-serial transmitter with single/repeat/gap modes; P2S_PARITY_EN appends a per-lane even-parity bit.
// Latency: first bit on the lanes the cycle after accept; frame lasts DATA_W (or DATA_W+1) enabled cycles.
// Backpressure: READY only in IDLE or on the last frame bit (modes other than gap); ENB low freezes everything.
module p2s_cond #(
    parameter int DATA_W = 8
) (
    input logic      IN_CLK_p2s,
    input logic      IN_RESET_p2s,
    p2s_cond_if.slave bus
);
    localparam int CW = $clog2(DATA_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
`ifdef P2S_PARITY_EN
    localparam logic [1:0] PAR   = 2'd3;
`endif

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0][DATA_W-1:0]  sh_q, sh_d;
    logic [3:0][DATA_W-1:0]  hold_q, hold_d;
    logic [1:0]              mode_q, mode_d;
    logic                    dir_q, dir_d;

    logic [3:0][DATA_W-1:0]  in_word;
    logic                    last_dat;
    logic                    eof;
    logic                    ready;
    logic                    accept;

    assign in_word  = {bus.IN_LANE3_p2s, bus.IN_LANE2_p2s, bus.IN_LANE1_p2s, bus.IN_LANE0_p2s};
    assign last_dat = (state_q == SHIFT) && (cnt_q == CW'(DATA_W - 1));
`ifdef P2S_PARITY_EN
    assign eof      = (state_q == PAR);
`else
    assign eof      = last_dat;
`endif
    // Reserved mode 11 follows single mode, so only gap mode closes the end-of-frame window.
    assign ready    = bus.IN_ENB_p2s && !IN_RESET_p2s &&
                      ((state_q == IDLE) || (eof && (mode_q != 2'b10)));
    assign accept   = bus.IN_VALID_p2s && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        if (bus.IN_ENB_p2s) begin
            case (state_q)
                SHIFT: begin
                    if (!last_dat) begin
                        for (int i = 0; i < 4; i++) begin
                            sh_d[i] = dir_q ? (sh_q[i] >> 1) : (sh_q[i] << 1);
                        end
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef P2S_PARITY_EN
                    else begin
                        state_d = PAR;
                        cnt_d   = cnt_q + 1'b1;
                    end
`endif
                end
                GAP:     state_d = IDLE;
                default: ;
            endcase
            if (eof) begin
                case (mode_q)
                    2'b01: begin
                        sh_d    = hold_q;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                    2'b10:   state_d = GAP;
                    default: state_d = IDLE;
                endcase
            end
            if (accept) begin
                sh_d    = in_word;
                hold_d  = in_word;
                mode_d  = bus.IN_MODO_p2s;
                dir_d   = bus.IN_DIR_p2s;
                cnt_d   = '0;
                state_d = SHIFT;
            end
        end
    end

    always_ff @(posedge IN_CLK_p2s) begin
        if (IN_RESET_p2s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            hold_q  <= '0;
            mode_q  <= 2'b00;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        bus.OUT_LANE_p2s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (state_q == SHIFT) begin
                bus.OUT_LANE_p2s[i] = dir_q ? sh_q[i][0] : sh_q[i][DATA_W-1];
            end
`ifdef P2S_PARITY_EN
            else if (state_q == PAR) begin
                bus.OUT_LANE_p2s[i] = ^hold_q[i];
            end
`endif
        end
    end

`ifdef P2S_PARITY_EN
    assign bus.OUT_ACTIVE_p2s = (state_q == SHIFT) || (state_q == PAR);
`else
    assign bus.OUT_ACTIVE_p2s = (state_q == SHIFT);
`endif
    assign bus.OUT_FRAME_p2s  = (state_q == SHIFT) && (cnt_q == '0);
    assign bus.OUT_DONE_p2s   = eof;
    assign bus.OUT_READY_p2s  = ready;
endmodule

// File: tb/tb_p2s_cond.sv
// Directed bench for p2s_cond: table of single-mode frames plus reset, repeat, gap and freeze sequences.
module tb_p2s_cond;
    localparam int DW = 8;
`ifdef P2S_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    p2s_cond_if #(.DATA_W(DW)) bus ();
    p2s_cond #(.DATA_W(DW)) dut (.IN_CLK_p2s(clk), .IN_RESET_p2s(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] w3, w2, w1, w0;
        logic       dir;
        logic [7:0] s3, s2, s1, s0;   // expected serial sequence per lane, bit 7 = first cycle
        logic [3:0] par;              // expected parity-cycle lanes
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_lane(input logic [7:0] s3, input logic [7:0] s2,
                                            input logic [7:0] s1, input logic [7:0] s0,
                                            input logic [3:0] par, input int c);
        if (c > 8) return par;
        return {s3[8-c], s2[8-c], s1[8-c], s0[8-c]};
    endfunction

    task automatic send(input logic [7:0] w3, input logic [7:0] w2, input logic [7:0] w1,
                        input logic [7:0] w0, input logic [1:0] m, input logic d);
        int n = 0;
        while (!bus.OUT_READY_p2s && n < 50) begin
            tick();
            n++;
        end
        chk("ready before send", {31'd0, bus.OUT_READY_p2s}, 32'd1);
        bus.IN_LANE3_p2s = w3;
        bus.IN_LANE2_p2s = w2;
        bus.IN_LANE1_p2s = w1;
        bus.IN_LANE0_p2s = w0;
        bus.IN_MODO_p2s  = m;
        bus.IN_DIR_p2s   = d;
        bus.IN_VALID_p2s = 1'b1;
        tick();
        bus.IN_VALID_p2s = 1'b0;
        bus.IN_LANE3_p2s = 8'hEE;
        bus.IN_LANE2_p2s = 8'hEE;
        bus.IN_LANE1_p2s = 8'hEE;
        bus.IN_LANE0_p2s = 8'hEE;
        bus.IN_DIR_p2s   = ~d;
        bus.IN_MODO_p2s  = 2'b11;
    endtask

    // Checks cycles first..last of a frame; ticks between cycles, not before the first or after the last.
    task automatic run_cycles(input logic [7:0] s3, input logic [7:0] s2, input logic [7:0] s1,
                              input logic [7:0] s0, input logic [3:0] par,
                              input int first, input int last, input string nm);
        for (int c = first; c <= last; c++) begin
            if (c != first) tick();
            chk($sformatf("%s lane c%0d", nm, c), {28'd0, bus.OUT_LANE_p2s},
                {28'd0, exp_lane(s3, s2, s1, s0, par, c)});
            chk($sformatf("%s frm/act/done c%0d", nm, c),
                {29'd0, bus.OUT_FRAME_p2s, bus.OUT_ACTIVE_p2s, bus.OUT_DONE_p2s},
                {29'd0, (c == 1), 1'b1, (c == FL)});
        end
    endtask

    task automatic chk_idle(input string nm, input logic exp_rdy);
        chk($sformatf("%s lane", nm), {28'd0, bus.OUT_LANE_p2s}, 32'd0);
        chk($sformatf("%s frm/act/done", nm),
            {29'd0, bus.OUT_FRAME_p2s, bus.OUT_ACTIVE_p2s, bus.OUT_DONE_p2s}, 32'd0);
        chk($sformatf("%s ready", nm), {31'd0, bus.OUT_READY_p2s}, {31'd0, exp_rdy});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'hA5, 8'hFF, 8'h00, 8'h3C, 1'b0, 8'hA5, 8'hFF, 8'h00, 8'h3C, 4'b0000};
        tbl[1] = '{8'hA5, 8'hFF, 8'h01, 8'h3C, 1'b1, 8'hA5, 8'hFF, 8'h80, 8'h3C, 4'b0010};
        tbl[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 8'h48, 8'h2C, 8'h6A, 8'h1E, 4'b0100};
        tbl[3] = '{8'h80, 8'h01, 8'hC0, 8'h03, 1'b0, 8'h80, 8'h01, 8'hC0, 8'h03, 4'b1100};
        tbl[4] = '{8'h07, 8'h00, 8'hFF, 8'h01, 1'b0, 8'h07, 8'h00, 8'hFF, 8'h01, 4'b1001};

        rst = 1'b1;
        bus.IN_ENB_p2s   = 1'b1;
        bus.IN_VALID_p2s = 1'b0;
        bus.IN_LANE3_p2s = '0;
        bus.IN_LANE2_p2s = '0;
        bus.IN_LANE1_p2s = '0;
        bus.IN_LANE0_p2s = '0;
        bus.IN_MODO_p2s  = 2'b00;
        bus.IN_DIR_p2s   = 1'b0;
        tick();
        tick();
        chk_idle("in reset", 1'b0);
        rst = 1'b0;
        #1;
        chk_idle("after reset", 1'b1);

        // Single-mode frames from the table
        for (int v = 0; v < 5; v++) begin
            send(tbl[v].w3, tbl[v].w2, tbl[v].w1, tbl[v].w0, 2'b00, tbl[v].dir);
            run_cycles(tbl[v].s3, tbl[v].s2, tbl[v].s1, tbl[v].s0, tbl[v].par, 1, FL,
                       $sformatf("vec%0d", v));
            chk($sformatf("vec%0d ready last", v), {31'd0, bus.OUT_READY_p2s}, 32'd1);
            tick();
            chk_idle($sformatf("vec%0d idle", v), 1'b1);
        end

        // Reset mid-frame aborts with no DONE
        send(8'hA5, 8'hFF, 8'h00, 8'h3C, 2'b00, 1'b0);
        run_cycles(8'hA5, 8'hFF, 8'h00, 8'h3C, 4'b0000, 1, 3, "abort");
        rst = 1'b1;
        tick();
        chk_idle("abort reset", 1'b0);
        rst = 1'b0;
        tick();
        chk_idle("abort idle", 1'b1);

        // Repeat mode: back-to-back new word, then autonomous resends, then exit via single-mode word
        send(8'h5A, 8'h5A, 8'h5A, 8'h5A, 2'b01, 1'b0);
        run_cycles(8'h5A, 8'h5A, 8'h5A, 8'h5A, 4'b0000, 1, FL, "rep first");
        chk("rep ready last", {31'd0, bus.OUT_READY_p2s}, 32'd1);
        send(8'h81, 8'h81, 8'h81, 8'h81, 2'b01, 1'b0);
        for (int r = 0; r < 3; r++) begin
            run_cycles(8'h81, 8'h81, 8'h81, 8'h81, 4'b0000, 1, FL, $sformatf("rep81 #%0d", r));
            chk($sformatf("rep81 #%0d ready", r), {31'd0, bus.OUT_READY_p2s}, 32'd1);
            if (r < 2) tick();
        end
        send(8'hA5, 8'hFF, 8'h00, 8'h3C, 2'b00, 1'b0);
        run_cycles(8'hA5, 8'hFF, 8'h00, 8'h3C, 4'b0000, 1, FL, "rep exit");
        tick();
        chk_idle("rep exit idle", 1'b1);

        // Gap mode with a 3-cycle freeze mid-frame; VALID during freeze must be ignored
        send(8'hA5, 8'hFF, 8'h00, 8'h3C, 2'b10, 1'b0);
        run_cycles(8'hA5, 8'hFF, 8'h00, 8'h3C, 4'b0000, 1, 3, "gap");
        bus.IN_ENB_p2s   = 1'b0;
        bus.IN_VALID_p2s = 1'b1;
        bus.IN_LANE3_p2s = 8'h00;
        bus.IN_LANE0_p2s = 8'hFF;
        for (int f = 0; f < 3; f++) begin
            tick();
            chk($sformatf("freeze%0d lane", f), {28'd0, bus.OUT_LANE_p2s},
                {28'd0, exp_lane(8'hA5, 8'hFF, 8'h00, 8'h3C, 4'b0000, 3)});
            chk($sformatf("freeze%0d frm/act/done", f),
                {29'd0, bus.OUT_FRAME_p2s, bus.OUT_ACTIVE_p2s, bus.OUT_DONE_p2s}, 32'b010);
            chk($sformatf("freeze%0d ready", f), {31'd0, bus.OUT_READY_p2s}, 32'd0);
        end
        bus.IN_VALID_p2s = 1'b0;
        bus.IN_ENB_p2s   = 1'b1;
        tick();
        run_cycles(8'hA5, 8'hFF, 8'h00, 8'h3C, 4'b0000, 4, FL, "gap resume");
        chk("gap ready last", {31'd0, bus.OUT_READY_p2s}, 32'd0);
        tick();
        chk_idle("gap cycle", 1'b0);
        tick();
        chk_idle("gap idle", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
